// File: rtl/hamming_pkg.sv
// Shared types, status codes and elaboration-time helpers for the SECDED decoder.
// The helpers place the parity and data bits inside the codeword.
package hamming_pkg;

  typedef logic [1:0] status_t;

  localparam status_t ST_CLEAN  = 2'b00;
  localparam status_t ST_CORR   = 2'b01;
  localparam status_t ST_UNCORR = 2'b10;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int calc_parity_bits(input int data_w);
    int p;
    p = 0;
    for (int i = 1; i <= 8; i++) begin
      if (p == 0 && (1 << i) >= data_w + i + 1) p = i;
    end
    return p;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // Codeword position of data bit k: the k-th non-power-of-two position above 0.
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 3; i < 256; i++) begin
      if (!is_pow2(i)) begin
        if (cnt == k && pos == 0) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// Combinational SECDED logic. The syndrome side works on the incoming codeword.
// The correction side works on the codeword held in stage 1.
module hamming_secded_core
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int P      = calc_parity_bits(DATA_W),
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [P-1:0]      syndrome,
  output logic              parity,
  input  logic [CODE_W-1:0] held_code,
  input  logic [P-1:0]      held_syndrome,
  input  logic              held_parity,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        status
);

  logic [CODE_W-1:0] fixed;
  logic              unused_fixed;

  always_comb begin
    syndrome = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (code[i]) syndrome = syndrome ^ P'(i);
    end
  end

  assign parity = ^code;

  // A syndrome pointing past the last position cannot be a single-bit error.
  always_comb begin
    fixed  = held_code;
    status = ST_CLEAN;
    if (held_syndrome == '0) begin
      status = held_parity ? ST_CORR : ST_CLEAN;
    end else if (!held_parity) begin
      status = ST_UNCORR;
    end else if (int'(held_syndrome) > CODE_W - 1) begin
      status = ST_UNCORR;
    end else begin
      status = ST_CORR;
      for (int i = 1; i < CODE_W; i++) begin
        if (held_syndrome == P'(i)) fixed[i] = ~fixed[i];
      end
    end
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_extract
    assign data[k] = fixed[data_pos(k)];
  end

  assign unused_fixed = ^fixed;

endmodule

// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage pipelined SECDED decoder with valid/ready handshake,
// saturating error counters and a sticky first-uncorrectable capture.
module hamming_secded_stream_decoder
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 16,
  localparam int P      = calc_parity_bits(DATA_W),
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_status,
  output logic [P-1:0]      out_syndrome,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic              first_err_valid,
  output logic [P-1:0]      first_err_syn
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              en;
  logic              xfer;
  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [P-1:0]      s1_syndrome;
  logic              s1_parity;
  logic [P-1:0]      syndrome;
  logic              parity;
  logic [DATA_W-1:0] fixed_data;
  status_t           fixed_status;
  logic [CNT_W-1:0]  corr_next;
  logic [CNT_W-1:0]  uncorr_next;
  logic              first_valid_next;
  logic [P-1:0]      first_syn_next;

  // Both stages advance together; a stalled output freezes the whole pipe.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign xfer     = out_valid && out_ready;

  hamming_secded_core #(
    .DATA_W(DATA_W)
  ) core (
    .code          (in_code),
    .syndrome      (syndrome),
    .parity        (parity),
    .held_code     (s1_code),
    .held_syndrome (s1_syndrome),
    .held_parity   (s1_parity),
    .data          (fixed_data),
    .status        (fixed_status)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_code     <= '0;
      s1_syndrome <= '0;
      s1_parity   <= 1'b0;
    end else if (en) begin
      s1_valid    <= in_valid;
      s1_code     <= in_code;
      s1_syndrome <= syndrome;
      s1_parity   <= parity;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_status   <= ST_CLEAN;
      out_syndrome <= '0;
    end else if (en) begin
      out_valid    <= s1_valid;
      out_data     <= fixed_data;
      out_status   <= fixed_status;
      out_syndrome <= s1_syndrome;
    end
  end

  // Clear is applied first so a transfer in the same cycle still counts once.
  always_comb begin
    corr_next        = clr_cnt ? '0 : corr_cnt;
    uncorr_next      = clr_cnt ? '0 : uncorr_cnt;
    first_valid_next = clr_cnt ? 1'b0 : first_err_valid;
    first_syn_next   = clr_cnt ? '0 : first_err_syn;
    if (xfer && out_status == ST_CORR && corr_next != CNT_MAX) begin
      corr_next = corr_next + CNT_W'(1);
    end
    if (xfer && out_status == ST_UNCORR) begin
      if (uncorr_next != CNT_MAX) uncorr_next = uncorr_next + CNT_W'(1);
      if (!first_valid_next) begin
        first_valid_next = 1'b1;
        first_syn_next   = out_syndrome;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt        <= '0;
      uncorr_cnt      <= '0;
      first_err_valid <= 1'b0;
      first_err_syn   <= '0;
    end else begin
      corr_cnt        <= corr_next;
      uncorr_cnt      <= uncorr_next;
      first_err_valid <= first_valid_next;
      first_err_syn   <= first_syn_next;
    end
  end

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Directed bench for the SECDED stream decoder (DATA_W=8, CNT_W=2).
// Codeword 0x144E carries data 0xA5; error patterns are derived from it by hand.
module tb_hamming_secded_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_status;
  logic [3:0]  out_syndrome;
  logic        clr_cnt;
  logic [1:0]  corr_cnt;
  logic [1:0]  uncorr_cnt;
  logic        first_err_valid;
  logic [3:0]  first_err_syn;

  int checks = 0;
  int errors = 0;

  hamming_secded_stream_decoder #(
    .DATA_W(8),
    .CNT_W (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_code         (in_code),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_status      (out_status),
    .out_syndrome    (out_syndrome),
    .clr_cnt         (clr_cnt),
    .corr_cnt        (corr_cnt),
    .uncorr_cnt      (uncorr_cnt),
    .first_err_valid (first_err_valid),
    .first_err_syn   (first_err_syn)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [12:0] code, output logic [7:0] d,
                          output logic [1:0] st, output logic [3:0] sy, output int lat);
    in_valid  = 1'b1;
    in_code   = code;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    d  = out_data;
    st = out_status;
    sy = out_syndrome;
    tick();
  endtask

  task automatic pulse_clear();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_out_data got %h want 00", out_data); end
    checks++; if (out_status !== 2'b00) begin errors++; $display("[TB] FAIL rst_status got %b want 00", out_status); end
    checks++; if (out_syndrome !== 4'd0) begin errors++; $display("[TB] FAIL rst_syndrome got %0d want 0", out_syndrome); end
    checks++; if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rst_counters got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
    checks++; if (first_err_valid !== 1'b0 || first_err_syn !== 4'd0) begin errors++; $display("[TB] FAIL rst_sticky got %b/%0d want 0/0", first_err_valid, first_err_syn); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_clean();
    logic [7:0] d; logic [1:0] st; logic [3:0] sy; int lat;
    run_word(13'h144E, d, st, sy, lat);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL clean_latency got %0d want 2", lat); end
    checks++; if (d !== 8'hA5) begin errors++; $display("[TB] FAIL clean_data got %h want a5", d); end
    checks++; if (st !== 2'b00) begin errors++; $display("[TB] FAIL clean_status got %b want 00", st); end
    checks++; if (sy !== 4'd0) begin errors++; $display("[TB] FAIL clean_syndrome got %0d want 0", sy); end
    checks++; if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin errors++; $display("[TB] FAIL clean_counters got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
  endtask

  task automatic test_single_error();
    logic [7:0] d; logic [1:0] st; logic [3:0] sy; int lat;
    run_word(13'h140E, d, st, sy, lat);
    checks++; if (d !== 8'hA5) begin errors++; $display("[TB] FAIL pos6_data got %h want a5", d); end
    checks++; if (st !== 2'b01) begin errors++; $display("[TB] FAIL pos6_status got %b want 01", st); end
    checks++; if (sy !== 4'd6) begin errors++; $display("[TB] FAIL pos6_syndrome got %0d want 6", sy); end
    checks++; if (corr_cnt !== 2'd1) begin errors++; $display("[TB] FAIL pos6_corr_cnt got %0d want 1", corr_cnt); end
    run_word(13'h144F, d, st, sy, lat);
    checks++; if (d !== 8'hA5) begin errors++; $display("[TB] FAIL bit0_data got %h want a5", d); end
    checks++; if (st !== 2'b01) begin errors++; $display("[TB] FAIL bit0_status got %b want 01", st); end
    checks++; if (sy !== 4'd0) begin errors++; $display("[TB] FAIL bit0_syndrome got %0d want 0", sy); end
    checks++; if (corr_cnt !== 2'd2 || uncorr_cnt !== 2'd0) begin errors++; $display("[TB] FAIL bit0_counters got %0d/%0d want 2/0", corr_cnt, uncorr_cnt); end
  endtask

  task automatic test_uncorrectable();
    logic [7:0] d; logic [1:0] st; logic [3:0] sy; int lat;
    run_word(13'h1046, d, st, sy, lat);
    checks++; if (st !== 2'b10) begin errors++; $display("[TB] FAIL double_status got %b want 10", st); end
    checks++; if (sy !== 4'd9) begin errors++; $display("[TB] FAIL double_syndrome got %0d want 9", sy); end
    checks++; if (d !== 8'h84) begin errors++; $display("[TB] FAIL double_raw_data got %h want 84", d); end
    checks++; if (uncorr_cnt !== 2'd1 || corr_cnt !== 2'd2) begin errors++; $display("[TB] FAIL double_counters got %0d/%0d want 2/1", corr_cnt, uncorr_cnt); end
    checks++; if (first_err_valid !== 1'b1 || first_err_syn !== 4'd9) begin errors++; $display("[TB] FAIL double_sticky got %b/%0d want 1/9", first_err_valid, first_err_syn); end
    run_word(13'h155C, d, st, sy, lat);
    checks++; if (st !== 2'b10) begin errors++; $display("[TB] FAIL triple_status got %b want 10", st); end
    checks++; if (sy !== 4'd13) begin errors++; $display("[TB] FAIL triple_syndrome got %0d want 13", sy); end
    checks++; if (d !== 8'hA5) begin errors++; $display("[TB] FAIL triple_raw_data got %h want a5", d); end
    checks++; if (uncorr_cnt !== 2'd2) begin errors++; $display("[TB] FAIL triple_uncorr_cnt got %0d want 2", uncorr_cnt); end
    checks++; if (first_err_valid !== 1'b1 || first_err_syn !== 4'd9) begin errors++; $display("[TB] FAIL triple_sticky got %b/%0d want 1/9", first_err_valid, first_err_syn); end
  endtask

  task automatic test_backpressure();
    int sent; int rcv; logic [3:0] held_syn;
    sent = 0; rcv = 0; held_syn = '0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (sent < 8);
      in_code   = 13'h144E ^ (13'd1 << (sent + 1));
      #1;
      if (out_valid && !out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready cyc %0d got %b want 0", cyc, in_ready); end
        if (cyc > 5) begin
          checks++; if (out_syndrome !== held_syn) begin errors++; $display("[TB] FAIL stall_hold cyc %0d got %0d want %0d", cyc, out_syndrome, held_syn); end
        end
        held_syn = out_syndrome;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_syndrome !== 4'(rcv + 1) || out_status !== 2'b01 || out_data !== 8'hA5) begin
          errors++;
          $display("[TB] FAIL bp_order word %0d got syn %0d st %b data %h want syn %0d st 01 data a5", rcv, out_syndrome, out_status, out_data, rcv + 1);
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (rcv !== 8 || sent !== 8) begin errors++; $display("[TB] FAIL bp_count got sent %0d recv %0d want 8/8", sent, rcv); end
    checks++; if (corr_cnt !== 2'd3) begin errors++; $display("[TB] FAIL bp_corr_saturated got %0d want 3", corr_cnt); end
  endtask

  task automatic test_full_rate();
    logic [12:0] codes [8];
    logic [1:0]  exp_st [8];
    logic [3:0]  exp_sy [8];
    logic [7:0]  exp_d [8];
    int sent; int rcv; int first_cyc; int last_cyc;
    codes  = '{13'h144E, 13'h140E, 13'h144F, 13'h1046, 13'h155C, 13'h144E, 13'h1046, 13'h144F};
    exp_st = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01};
    exp_sy = '{4'd0, 4'd6, 4'd0, 4'd9, 4'd13, 4'd0, 4'd9, 4'd0};
    exp_d  = '{8'hA5, 8'hA5, 8'hA5, 8'h84, 8'hA5, 8'hA5, 8'h84, 8'hA5};
    pulse_clear();
    checks++; if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0 || first_err_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_idle got %0d/%0d/%b want 0/0/0", corr_cnt, uncorr_cnt, first_err_valid); end
    sent = 0; rcv = 0; first_cyc = 0; last_cyc = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && rcv < 8; cyc++) begin
      in_valid = (sent < 8);
      in_code  = (sent < 8) ? codes[sent] : 13'h0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_in_ready cyc %0d got %b want 1", cyc, in_ready); end
      if (out_valid) begin
        checks++;
        if (out_status !== exp_st[rcv] || out_syndrome !== exp_sy[rcv] || out_data !== exp_d[rcv]) begin
          errors++;
          $display("[TB] FAIL full_word %0d got st %b syn %0d data %h want st %b syn %0d data %h", rcv, out_status, out_syndrome, out_data, exp_st[rcv], exp_sy[rcv], exp_d[rcv]);
        end
        if (rcv == 0) first_cyc = cyc;
        last_cyc = cyc;
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (rcv !== 8 || last_cyc - first_cyc !== 7) begin errors++; $display("[TB] FAIL full_rate got %0d words over %0d cycles want 8 over 7", rcv, last_cyc - first_cyc); end
    checks++; if (corr_cnt !== 2'd3 || uncorr_cnt !== 2'd3) begin errors++; $display("[TB] FAIL full_counters got %0d/%0d want 3/3", corr_cnt, uncorr_cnt); end
    checks++; if (first_err_valid !== 1'b1 || first_err_syn !== 4'd9) begin errors++; $display("[TB] FAIL full_sticky got %b/%0d want 1/9", first_err_valid, first_err_syn); end
  endtask

  task automatic test_saturation();
    logic [7:0] d; logic [1:0] st; logic [3:0] sy; int lat;
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      run_word(13'h140E, d, st, sy, lat);
      if (i == 1) begin
        checks++; if (corr_cnt !== 2'd2) begin errors++; $display("[TB] FAIL sat_mid got %0d want 2", corr_cnt); end
      end
    end
    checks++; if (corr_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat_corr got %0d want 3", corr_cnt); end
    checks++; if (uncorr_cnt !== 2'd0) begin errors++; $display("[TB] FAIL sat_uncorr got %0d want 0", uncorr_cnt); end
  endtask

  task automatic test_clear_coincident();
    logic [7:0] d; logic [1:0] st; logic [3:0] sy; int lat;
    in_valid = 1'b1; in_code = 13'h140E; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL coinc_valid got %b want 1", out_valid); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++; if (corr_cnt !== 2'd1) begin errors++; $display("[TB] FAIL coinc_corr got %0d want 1", corr_cnt); end
    run_word(13'h1046, d, st, sy, lat);
    checks++; if (first_err_syn !== 4'd9 || uncorr_cnt !== 2'd1) begin errors++; $display("[TB] FAIL coinc_pre got syn %0d cnt %0d want 9/1", first_err_syn, uncorr_cnt); end
    in_valid = 1'b1; in_code = 13'h155C;
    tick();
    in_valid = 1'b0;
    tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++; if (uncorr_cnt !== 2'd1 || corr_cnt !== 2'd0) begin errors++; $display("[TB] FAIL coinc_uncorr got %0d/%0d want 0/1", corr_cnt, uncorr_cnt); end
    checks++; if (first_err_valid !== 1'b1 || first_err_syn !== 4'd13) begin errors++; $display("[TB] FAIL coinc_sticky got %b/%0d want 1/13", first_err_valid, first_err_syn); end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; in_code = 13'h144E; out_ready = 1'b1;
    tick();
    in_code = 13'h140E;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", out_valid); end
    checks++; if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin errors++; $display("[TB] FAIL midrst_counters got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
    checks++; if (first_err_valid !== 1'b0 || first_err_syn !== 4'd0) begin errors++; $display("[TB] FAIL midrst_sticky got %b/%0d want 0/0", first_err_valid, first_err_syn); end
    rst = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flushed got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_uncorrectable();
    test_backpressure();
    test_full_rate();
    test_saturation();
    test_clear_coincident();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
